// File: rtl/gcd_driver_if.sv
// Bundle of the host operand port, the GCD core start/done port and the result port.
// The driver uses the master view; the surrounding environment uses the slave view.
interface gcd_driver_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             gcd_start;
    logic [WIDTH-1:0] gcd_a;
    logic [WIDTH-1:0] gcd_b;
    logic             gcd_done;
    logic [WIDTH-1:0] gcd_result;
    logic             gcd_error;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_error;
    logic             out_timeout;

    modport master (
        input  in_valid, in_a, in_b,
        input  gcd_done, gcd_result, gcd_error,
        input  out_ready,
        output in_ready,
        output gcd_start, gcd_a, gcd_b,
        output out_valid, out_result, out_error, out_timeout
    );

    modport slave (
        output in_valid, in_a, in_b,
        output gcd_done, gcd_result, gcd_error,
        output out_ready,
        input  in_ready,
        input  gcd_start, gcd_a, gcd_b,
        input  out_valid, out_result, out_error, out_timeout
    );
endinterface

// File: rtl/gcd_driver.sv
// Queues operand pairs and sequences the GCD core's start/done handshake, one job at a time.
// Optional response statistics counters are enabled with the GCD_DRV_STATS_EN macro.
module gcd_driver #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         rst,
    gcd_driver_if.master bus,
    output logic         busy
`ifdef GCD_DRV_STATS_EN
    ,
    output logic [15:0]  stat_jobs,
    output logic [15:0]  stat_errors,
    output logic [15:0]  stat_timeouts
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;

    logic [2*WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   count_nxt_s;
    logic               push_s;
    logic               pop_s;

    logic               done_q_r;
    logic               done_rise_s;
    logic [TMR_W-1:0]   timer_r;
    logic               timeout_hit_s;
    logic               capture_done_s;
    logic               capture_timeout_s;
    logic               accept_s;

    logic               in_ready_r;
    logic               start_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic               out_valid_r;
    logic [WIDTH-1:0]   result_r;
    logic               error_r;
    logic               timeout_r;
    logic               busy_r;

    assign bus.in_ready    = in_ready_r;
    assign bus.gcd_start   = start_r;
    assign bus.gcd_a       = a_r;
    assign bus.gcd_b       = b_r;
    assign bus.out_valid   = out_valid_r;
    assign bus.out_result  = result_r;
    assign bus.out_error   = error_r;
    assign bus.out_timeout = timeout_r;
    assign busy            = busy_r;

    // Edge detect on the core's done level and timeout comparison.
    always_comb begin
        done_rise_s   = bus.gcd_done & ~done_q_r;
        timeout_hit_s = (timer_r == TMR_W'(TIMEOUT - 1));
    end

    // FIFO push/pop qualification and next occupancy.
    always_comb begin
        push_s      = bus.in_valid & in_ready_r;
        count_nxt_s = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; a done edge outside WAIT is deliberately not looked at.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (count_r != CNT_W'(0)) begin
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_nxt_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (done_rise_s || timeout_hit_s) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (bus.out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Per-state control strobes; done_rise wins over the timeout in the same cycle.
    always_comb begin
        pop_s             = 1'b0;
        capture_done_s    = 1'b0;
        capture_timeout_s = 1'b0;
        accept_s          = 1'b0;
        case (state_r)
            ST_IDLE: begin
                pop_s = (count_r != CNT_W'(0));
            end
            ST_ISSUE: begin
                pop_s = 1'b0;
            end
            ST_WAIT: begin
                if (done_rise_s) begin
                    capture_done_s = 1'b1;
                end else if (timeout_hit_s) begin
                    capture_timeout_s = 1'b1;
                end else begin
                    capture_done_s = 1'b0;
                end
            end
            ST_RESP: begin
                accept_s = bus.out_ready;
            end
            default: begin
                pop_s = 1'b0;
            end
        endcase
    end

    // Done level history for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_q_r <= 1'b0;
        end else begin
            done_q_r <= bus.gcd_done;
        end
    end

    // Operand FIFO storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {(2*WIDTH){1'b0}};
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= {bus.in_a, bus.in_b};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_nxt_s;
        end
    end

    // WAIT-state cycle counter, cleared while issuing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer_r <= TMR_W'(0);
        end else if (state_r == ST_ISSUE) begin
            timer_r <= TMR_W'(0);
        end else if (state_r == ST_WAIT) begin
            timer_r <= timer_r + TMR_W'(1);
        end
    end

    // Operands to the core change only when a pair is popped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_r <= WIDTH'(0);
            b_r <= WIDTH'(0);
        end else if (pop_s) begin
            a_r <= mem_r[rd_ptr_r][2*WIDTH-1:WIDTH];
            b_r <= mem_r[rd_ptr_r][WIDTH-1:0];
        end
    end

    // Status outputs registered from next-cycle state and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ready_r  <= 1'b1;
            start_r     <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            in_ready_r  <= (count_nxt_s != CNT_W'(DEPTH));
            start_r     <= (state_nxt_s == ST_ISSUE);
            out_valid_r <= (state_nxt_s == ST_RESP);
            busy_r      <= (state_nxt_s != ST_IDLE) || (count_nxt_s != CNT_W'(0));
        end
    end

    // Response capture; values hold until the next job completes or times out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_r  <= WIDTH'(0);
            error_r   <= 1'b0;
            timeout_r <= 1'b0;
        end else if (capture_done_s) begin
            result_r  <= bus.gcd_result;
            error_r   <= bus.gcd_error;
            timeout_r <= 1'b0;
        end else if (capture_timeout_s) begin
            result_r  <= WIDTH'(0);
            error_r   <= 1'b1;
            timeout_r <= 1'b1;
        end
    end

`ifdef GCD_DRV_STATS_EN
    logic [15:0] jobs_r;
    logic [15:0] errors_r;
    logic [15:0] timeouts_r;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

    // Saturating counters over accepted responses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            jobs_r     <= 16'd0;
            errors_r   <= 16'd0;
            timeouts_r <= 16'd0;
        end else if (accept_s) begin
            jobs_r <= sat_inc(jobs_r);
            if (timeout_r) begin
                timeouts_r <= sat_inc(timeouts_r);
            end else if (error_r) begin
                errors_r <= sat_inc(errors_r);
            end
        end
    end

    assign stat_jobs     = jobs_r;
    assign stat_errors   = errors_r;
    assign stat_timeouts = timeouts_r;
`else
    logic unused_accept_s;
    assign unused_accept_s = accept_s;
`endif

endmodule

// File: tb/tb_gcd_driver.sv
// Directed self-checking bench for gcd_driver with a small behavioural GCD core.
module tb_gcd_driver;
    localparam int W   = 32;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic busy;
`ifdef GCD_DRV_STATS_EN
    logic [15:0] stat_jobs, stat_errors, stat_timeouts;
`endif

    always #5 clk = ~clk;

    gcd_driver_if #(.WIDTH(W)) bus ();

    gcd_driver #(.WIDTH(W), .DEPTH(4), .TIMEOUT(TMO)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus.master),
        .busy (busy)
`ifdef GCD_DRV_STATS_EN
        ,
        .stat_jobs     (stat_jobs),
        .stat_errors   (stat_errors),
        .stat_timeouts (stat_timeouts)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    // Behavioural core: done rises a few cycles after start, zero operand flags ERROR.
    logic         m_done   = 1'b0;
    logic [W-1:0] m_result = '0;
    logic         m_error  = 1'b0;
    logic [W-1:0] ma = '0, mb = '0;
    int           cnt = 0;
    logic         never_done = 1'b0;

    function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x, y, t;
        x = a; y = b;
        while (y != 0) begin
            t = y; y = x % y; x = t;
        end
        return x;
    endfunction

    always @(posedge clk) begin
        if (bus.gcd_start) begin
            m_done <= 1'b0;
            cnt    <= 5;
            ma     <= bus.gcd_a;
            mb     <= bus.gcd_b;
        end else if (cnt > 0) begin
            cnt <= cnt - 1;
            if (cnt == 1 && !never_done) begin
                m_done   <= 1'b1;
                m_error  <= (ma == 0) || (mb == 0);
                m_result <= ((ma == 0) || (mb == 0)) ? '0 : ref_gcd(ma, mb);
            end
        end
    end

    assign bus.gcd_done   = m_done;
    assign bus.gcd_result = m_result;
    assign bus.gcd_error  = m_error;

    // Start pulse monitors: never during reset, never longer than one cycle.
    int   start_in_rst = 0;
    int   long_start   = 0;
    logic prev_start   = 1'b0;
    always @(negedge clk) begin
        if (!rst && bus.gcd_start) start_in_rst <= start_in_rst + 1;
        if (bus.gcd_start && prev_start) long_start <= long_start + 1;
        prev_start <= bus.gcd_start;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        while (!bus.in_ready && n < 100) begin
            tick();
            n++;
        end
        check_eq("push_ready", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 200) begin
            tick();
            lat++;
        end
        check_eq("resp_seen", bus.out_valid, 1);
    endtask

    task automatic wait_start();
        int n;
        n = 0;
        while (!bus.gcd_start && n < 50) begin
            tick();
            n++;
        end
        check_eq("start_seen", bus.gcd_start, 1);
    endtask

    logic [W-1:0] res [6];
    logic [W-1:0] exp6 [6];

    initial begin
        int   lat, got, cyc;
        logic stable, saw_valid, acc;

        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b1;
        rst           = 1'b0;

        // 1: reset held with in_valid asserted
        bus.in_valid = 1'b1; bus.in_a = 5; bus.in_b = 7;
        repeat (4) tick();
        check_eq("rst_in_ready", bus.in_ready, 1);
        check_eq("rst_start", bus.gcd_start, 0);
        check_eq("rst_out_valid", bus.out_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_gcd_a", bus.gcd_a, 0);
        check_eq("rst_result", {bus.out_result, bus.out_error, bus.out_timeout}, 0);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        check_eq("rst_no_start", start_in_rst, 0);

        // 2: (12,18) -> 6, start two cycles after acceptance
        bus.in_a = 12; bus.in_b = 18; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check_eq("t2_start_early", bus.gcd_start, 0);
        tick();
        check_eq("t2_start", bus.gcd_start, 1);
        check_eq("t2_gcd_a", bus.gcd_a, 12);
        check_eq("t2_gcd_b", bus.gcd_b, 18);
        lat = 0; stable = 1'b1;
        while (!bus.out_valid && lat < 100) begin
            tick();
            lat++;
            if (bus.gcd_a != 12 || bus.gcd_b != 18) stable = 1'b0;
        end
        check_eq("t2_latency", lat, 7);
        check_eq("t2_stable", stable, 1);
        check_eq("t2_result", bus.out_result, 6);
        check_eq("t2_error", bus.out_error, 0);
        check_eq("t2_timeout", bus.out_timeout, 0);
        tick();
        check_eq("t2_valid_drop", bus.out_valid, 0);

        // 3: zero operand -> ERROR
        push(0, 3);
        wait_valid(lat);
        check_eq("t3_result", bus.out_result, 0);
        check_eq("t3_error", bus.out_error, 1);
        check_eq("t3_timeout", bus.out_timeout, 0);
        tick();

        // 4: back-pressure, FIFO fills, ordering preserved
        bus.out_ready = 1'b0;
        push(4, 6); push(9, 6); push(10, 15); push(7, 21); push(8, 12);
        check_eq("t4_full", bus.in_ready, 0);
        bus.in_valid = 1'b1; bus.in_a = 5; bus.in_b = 5;
        repeat (15) tick();
        check_eq("t4_still_full", bus.in_ready, 0);
        check_eq("t4_held_valid", bus.out_valid, 1);
        check_eq("t4_held_result", bus.out_result, 2);
        bus.out_ready = 1'b1;
        got = 0; cyc = 0;
        while (got < 6 && cyc < 300) begin
            if (bus.out_valid) begin
                res[got] = bus.out_result;
                got++;
            end
            acc = bus.in_valid && bus.in_ready;
            tick();
            cyc++;
            if (acc) bus.in_valid = 1'b0;
        end
        check_eq("t4_count", got, 6);
        exp6[0] = 2; exp6[1] = 3; exp6[2] = 5; exp6[3] = 7; exp6[4] = 4; exp6[5] = 5;
        for (int i = 0; i < 6; i++) begin
            check_eq($sformatf("t4_res%0d", i), res[i], exp6[i]);
        end
        bus.in_valid = 1'b0;
        tick();

        // 5: timeout, then the next queued job runs normally
        never_done = 1'b1;
        push(9, 3);
        push(14, 21);
        wait_start();
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            tick();
            lat++;
        end
        never_done = 1'b0;
        check_eq("t5_latency", lat, 17);
        check_eq("t5_timeout", bus.out_timeout, 1);
        check_eq("t5_error", bus.out_error, 1);
        check_eq("t5_result", bus.out_result, 0);
        tick();
        wait_valid(lat);
        check_eq("t5_next_result", bus.out_result, 7);
        check_eq("t5_next_timeout", bus.out_timeout, 0);
        tick();
`ifdef GCD_DRV_STATS_EN
        check_eq("stat_jobs", stat_jobs, 10);
        check_eq("stat_errors", stat_errors, 1);
        check_eq("stat_timeouts", stat_timeouts, 1);
`endif

        // 6: reset during WAIT, late done from aborted job is dropped
        push(20, 30);
        wait_start();
        repeat (2) tick();
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        saw_valid = 1'b0;
        repeat (12) begin
            tick();
            if (bus.out_valid) saw_valid = 1'b1;
        end
        check_eq("t6_no_valid", saw_valid, 0);
        check_eq("t6_busy", busy, 0);
        check_eq("t6_in_ready", bus.in_ready, 1);
        push(20, 30);
        wait_valid(lat);
        check_eq("t6_result", bus.out_result, 10);
        check_eq("t6_timeout", bus.out_timeout, 0);
        tick();

        check_eq("start_pulse_width", long_start, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
